// File: rtl/noc_flit_sender_pkg.sv
// ---------------------------------------------------------------------------
// noc_flit_sender_pkg: shared FSM encoding and flit defaults for the sender.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif

package noc_flit_sender_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_BODY = 2'd2
   } state_e;

   localparam int C_NOC_DATA_W = `Noc_Data_Width;

   // Header occupies dest_x, dest_y, src_x, src_y and len, MSB-aligned.
   function automatic int hdr_bits(input int coord_w, input int len_w);
      return 4 * coord_w + len_w;
   endfunction

endpackage

`default_nettype wire

// File: rtl/noc_sender_out_reg.sv
// ---------------------------------------------------------------------------
// noc_sender_out_reg: holding output register for the flit port with load_ok.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module noc_sender_out_reg #(
   parameter int DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              load_i,
   input  logic              ready_i,
   input  logic [DATA_W-1:0] flit_i,
   input  logic              hdr_i,
   input  logic              tail_i,
   output logic              load_ok_o,
   output logic              valid_o,
   output logic [DATA_W-1:0] flit_o,
   output logic              hdr_o,
   output logic              tail_o
);

   logic              valid_q;
   logic [DATA_W-1:0] flit_q;
   logic              hdr_q;
   logic              tail_q;

   assign load_ok_o = !valid_q | ready_i;

   // Payload and flags only move on a real load so a stalled flit stays put.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         flit_q  <= '0;
         hdr_q   <= 1'b0;
         tail_q  <= 1'b0;
      end else if (load_ok_o) begin
         valid_q <= load_i;
         if (load_i) begin
            flit_q <= flit_i;
            hdr_q  <= hdr_i;
            tail_q <= tail_i;
         end
      end
   end

   assign valid_o = valid_q;
   assign flit_o  = flit_q;
   assign hdr_o   = hdr_q;
   assign tail_o  = tail_q;

endmodule

`default_nettype wire

// File: rtl/noc_flit_sender.sv
// ---------------------------------------------------------------------------
// noc_flit_sender: packet request + payload stream -> header/body/tail flits.
// Revision 1.0 -- optional stall watchdog: NOC_SENDER_STALL_WDOG_EN
// ---------------------------------------------------------------------------
`default_nettype none

`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif

module noc_flit_sender
   import noc_flit_sender_pkg::*;
#(
   parameter int DATA_W   = `Noc_Data_Width,
   parameter int COORD_W  = 4,
   parameter int LEN_W    = 4,
   parameter int SRC_X    = 0,
   parameter int SRC_Y    = 0,
   parameter int WDOG_CYC = 1024
) (
   input  logic               noc_clk,
   input  logic               rst_n,
   input  logic               pkt_valid,
   output logic               pkt_ready,
   input  logic [COORD_W-1:0] pkt_dest_x,
   input  logic [COORD_W-1:0] pkt_dest_y,
   input  logic [LEN_W-1:0]   pkt_len,
   input  logic               data_valid,
   output logic               data_ready,
   input  logic [DATA_W-1:0]  data,
   output logic               Noc_send_valid,
   input  logic               Noc_send_ready,
   output logic [DATA_W-1:0]  Noc_send_flit,
   input  logic               Noc_send_VCready,
   output logic               Noc_send_is_header,
   output logic               Noc_send_is_tail,
   output logic               busy,
   output logic               stall_err
);

   localparam int HDR_W = hdr_bits(COORD_W, LEN_W);

   state_e             state_q;
   logic [COORD_W-1:0] dx_q;
   logic [COORD_W-1:0] dy_q;
   logic [LEN_W-1:0]   len_q;
   logic [LEN_W-1:0]   rem_q;
   logic               busy_q;
   logic               en_q;

   logic               w_load_ok;
   logic               w_hdr_load;
   logic               w_body_load;
   logic               w_hdr_last;
   logic               w_body_last;
   logic               w_accept;
   logic               w_load;
   logic               w_tail;
   logic               w_tx_tail;
   logic [HDR_W-1:0]   w_hdr_fields;
   logic [DATA_W-1:0]  w_hdr;
   logic [DATA_W-1:0]  w_flit;

   assign w_hdr_fields = {dx_q, dy_q, COORD_W'(SRC_X), COORD_W'(SRC_Y), len_q};
   assign w_hdr        = DATA_W'(w_hdr_fields) << (DATA_W - HDR_W);

   assign w_hdr_load  = (state_q == ST_HDR) & Noc_send_VCready & w_load_ok;
   assign w_body_load = (state_q == ST_BODY) & data_valid & w_load_ok;
   assign w_hdr_last  = w_hdr_load & (len_q == '0);
   assign w_body_last = w_body_load & (rem_q == LEN_W'(1));

   // Accepting while the tail loads removes the bubble between packets.
   assign pkt_ready  = en_q & ((state_q == ST_IDLE) | w_hdr_last | w_body_last);
   assign w_accept   = pkt_valid & pkt_ready;
   assign data_ready = (state_q == ST_BODY) & w_load_ok;

   assign w_load    = w_hdr_load | w_body_load;
   assign w_flit    = w_hdr_load ? w_hdr : data;
   assign w_tail    = w_hdr_last | w_body_last;
   assign w_tx_tail = Noc_send_valid & Noc_send_ready & Noc_send_is_tail;
   assign busy      = busy_q;

   noc_sender_out_reg #(
      .DATA_W (DATA_W)
   ) u_out_reg (
      .clk_i     (noc_clk),
      .rst_ni    (rst_n),
      .load_i    (w_load),
      .ready_i   (Noc_send_ready),
      .flit_i    (w_flit),
      .hdr_i     (w_hdr_load),
      .tail_i    (w_tail),
      .load_ok_o (w_load_ok),
      .valid_o   (Noc_send_valid),
      .flit_o    (Noc_send_flit),
      .hdr_o     (Noc_send_is_header),
      .tail_o    (Noc_send_is_tail)
   );

   always_ff @(posedge noc_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         dx_q    <= '0;
         dy_q    <= '0;
         len_q   <= '0;
         rem_q   <= '0;
         busy_q  <= 1'b0;
         en_q    <= 1'b0;
      end else begin
         en_q <= 1'b1;
         if (w_accept) begin
            dx_q   <= pkt_dest_x;
            dy_q   <= pkt_dest_y;
            len_q  <= pkt_len;
            busy_q <= 1'b1;
         end else if (w_tx_tail && (state_q == ST_IDLE)) begin
            busy_q <= 1'b0;
         end
         case (state_q)
            ST_IDLE: begin
               if (w_accept) state_q <= ST_HDR;
            end
            ST_HDR: begin
               if (w_hdr_load) begin
                  if (len_q == '0) begin
                     state_q <= w_accept ? ST_HDR : ST_IDLE;
                  end else begin
                     rem_q   <= len_q;
                     state_q <= ST_BODY;
                  end
               end
            end
            ST_BODY: begin
               if (w_body_load) begin
                  rem_q <= rem_q - LEN_W'(1);
                  if (rem_q == LEN_W'(1)) state_q <= w_accept ? ST_HDR : ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

`ifdef NOC_SENDER_STALL_WDOG_EN
   localparam int WD_W = $clog2(WDOG_CYC + 1);

   logic [WD_W-1:0] wd_cnt_q;
   logic            stall_err_q;
   logic            w_stall;

   assign w_stall = Noc_send_valid & !Noc_send_ready;

   always_ff @(posedge noc_clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_cnt_q    <= '0;
         stall_err_q <= 1'b0;
      end else begin
         if (Noc_send_valid && Noc_send_ready) begin
            wd_cnt_q <= '0;
         end else if (w_stall && (wd_cnt_q != WD_W'(WDOG_CYC))) begin
            wd_cnt_q <= wd_cnt_q + WD_W'(1);
         end
         if (w_stall && (wd_cnt_q == WD_W'(WDOG_CYC - 1))) stall_err_q <= 1'b1;
      end
   end

   assign stall_err = stall_err_q;
`else
   assign stall_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_noc_flit_sender.sv
// ---------------------------------------------------------------------------
// tb_noc_flit_sender: directed and randomized checks of noc_flit_sender.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_noc_flit_sender;

   localparam int DW = 32;
   localparam int CW = 4;
   localparam int LW = 4;
   localparam int SX = 1;
   localparam int SY = 2;

   logic          noc_clk = 1'b0;
   logic          rst_n   = 1'b0;
   logic          pkt_valid = 1'b0;
   logic          pkt_ready;
   logic [CW-1:0] pkt_dest_x = '0;
   logic [CW-1:0] pkt_dest_y = '0;
   logic [LW-1:0] pkt_len = '0;
   logic          data_valid = 1'b0;
   logic          data_ready;
   logic [DW-1:0] data = '0;
   logic          Noc_send_valid;
   logic          Noc_send_ready = 1'b0;
   logic [DW-1:0] Noc_send_flit;
   logic          Noc_send_VCready = 1'b0;
   logic          Noc_send_is_header;
   logic          Noc_send_is_tail;
   logic          busy;
   logic          stall_err;

   noc_flit_sender #(
      .DATA_W (DW), .COORD_W (CW), .LEN_W (LW), .SRC_X (SX), .SRC_Y (SY), .WDOG_CYC (16)
   ) dut (
      .noc_clk            (noc_clk),
      .rst_n              (rst_n),
      .pkt_valid          (pkt_valid),
      .pkt_ready          (pkt_ready),
      .pkt_dest_x         (pkt_dest_x),
      .pkt_dest_y         (pkt_dest_y),
      .pkt_len            (pkt_len),
      .data_valid         (data_valid),
      .data_ready         (data_ready),
      .data               (data),
      .Noc_send_valid     (Noc_send_valid),
      .Noc_send_ready     (Noc_send_ready),
      .Noc_send_flit      (Noc_send_flit),
      .Noc_send_VCready   (Noc_send_VCready),
      .Noc_send_is_header (Noc_send_is_header),
      .Noc_send_is_tail   (Noc_send_is_tail),
      .busy               (busy),
      .stall_err          (stall_err)
   );

   always #5 noc_clk = ~noc_clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: packets, the concatenated payload stream and the flit sequence.
   int            pk_dx[$];
   int            pk_dy[$];
   int            pk_len[$];
   logic [DW-1:0] dq[$];
   logic [33:0]   ef[$];
   int            p_i = 0;
   int            d_i = 0;

   task automatic add_pkt(input int dx, input int dy, input int len);
      logic [DW-1:0] hdr;
      logic [DW-1:0] w;
      pk_dx.push_back(dx);
      pk_dy.push_back(dy);
      pk_len.push_back(len);
      hdr = DW'(dx * (1 << 28) + dy * (1 << 24) + SX * (1 << 20) + SY * (1 << 16) + len * (1 << 12));
      ef.push_back({1'b1, (len == 0), hdr});
      for (int i = 0; i < len; i++) begin
         w = DW'($urandom);
         dq.push_back(w);
         ef.push_back({1'b0, (i == len - 1), w});
      end
   endtask

   int          cyc = 0;
   int          vc_hold = 0;
   int          acc_cnt = 0;
   int          tail_cnt = 0;
   int          vcount = 0;
   int          first_cyc = -1;
   int          last_cyc = -1;
   logic        prev_v = 1'b0;
   logic        prev_r = 1'b0;
   logic        prev_vc = 1'b0;
   logic [33:0] prev_vec = '0;
   logic        s_valid;
   logic        s_hdr;

   task automatic step(input bit rnd);
      logic [33:0] cur;
      pkt_valid = (p_i < pk_len.size()) && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
      pkt_dest_x = (p_i < pk_len.size()) ? CW'(pk_dx[p_i]) : '0;
      pkt_dest_y = (p_i < pk_len.size()) ? CW'(pk_dy[p_i]) : '0;
      pkt_len    = (p_i < pk_len.size()) ? LW'(pk_len[p_i]) : '0;
      data_valid = (d_i < dq.size()) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      data       = (d_i < dq.size()) ? dq[d_i] : '0;
      Noc_send_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (vc_hold > 0) begin
         Noc_send_VCready = 1'b0;
         vc_hold--;
      end else begin
         Noc_send_VCready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
      #1;
      cyc++;
      cur = {Noc_send_is_header, Noc_send_is_tail, Noc_send_flit};
      s_valid = Noc_send_valid;
      s_hdr   = Noc_send_is_header;
      chk("busy", busy, (acc_cnt != tail_cnt));
      if (prev_v && !prev_r) begin
         chk("hold_valid", Noc_send_valid, 1'b1);
         chk("hold_flit", cur, prev_vec);
      end else if (Noc_send_valid && Noc_send_is_header) begin
         chk("vc_at_hdr_load", prev_vc, 1'b1);
      end
      if (Noc_send_valid) begin
         vcount++;
         if (first_cyc < 0) first_cyc = cyc;
      end
      if (Noc_send_valid && Noc_send_ready) begin
         last_cyc = cyc;
         if (ef.size() == 0) chk("extra_flit", cur, '0);
         else chk("flit", cur, ef.pop_front());
         if (Noc_send_is_tail) tail_cnt++;
      end
      if (pkt_valid && pkt_ready) begin
         p_i++;
         acc_cnt++;
      end
      if (data_valid && data_ready) d_i++;
      prev_v   = Noc_send_valid;
      prev_r   = Noc_send_ready;
      prev_vec = cur;
      prev_vc  = Noc_send_VCready;
      @(negedge noc_clk);
   endtask

   task automatic drain(input bit rnd, input int budget);
      int g;
      g = 0;
      while (ef.size() > 0 && g < budget) begin
         step(rnd);
         g++;
      end
      chk("drain_left", ef.size(), 0);
   endtask

   initial begin
      repeat (3) @(negedge noc_clk);
      chk("rst_pkt_ready", pkt_ready, 1'b0);
      chk("rst_data_ready", data_ready, 1'b0);
      chk("rst_valid", Noc_send_valid, 1'b0);
      chk("rst_flags", {Noc_send_is_header, Noc_send_is_tail}, 2'b00);
      chk("rst_flit", Noc_send_flit, '0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_stall", stall_err, 1'b0);
      rst_n = 1'b1;

      // Full-rate stream: len3 (2,1), len0, then two len1 back to back.
      add_pkt(2, 1, 3);
      add_pkt(7, 3, 0);
      add_pkt(4, 9, 1);
      add_pkt(11, 5, 1);
      vcount = 0;
      first_cyc = -1;
      drain(1'b0, 200);
      chk("burst_valid_cycles", vcount, 9);
      chk("burst_span", last_cyc - first_cyc + 1, 9);

      // Header must wait for VCready.
      add_pkt(5, 6, 2);
      vc_hold = 5;
      for (int i = 1; i <= 7; i++) begin
         step(1'b0);
         if (i <= 6) chk("vc_wait_no_valid", s_valid, 1'b0);
         else chk("vc_hdr_after_rise", {s_valid, s_hdr}, 2'b11);
      end
      drain(1'b0, 50);

      // Randomized traffic with stalls, bubbles and VC back-pressure.
      for (int i = 0; i < 40; i++) begin
         add_pkt($urandom_range(0, 15), $urandom_range(0, 15),
                 (i == 0) ? 15 : (i == 1) ? 0 : $urandom_range(0, 15));
      end
      drain(1'b1, 20000);
      chk("data_all_used", d_i, dq.size());
      chk("pkts_all_taken", p_i, pk_len.size());
      step(1'b0);
      chk("end_busy", busy, 1'b0);
      chk("end_stall_err", stall_err, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
